shared_reg_arbiter: RTL and testbench

Round-robin arbiter and write sequencer for a single shared WIDTH-bit D-flip-flop register, contended by N_REQ requesters. The block grants one requester at a time, captures that requester's data into the register on the cycle after grant, and then enforces a programmable guard interval before the next grant. It sits in front of the register bank in the datapath, replacing ad-hoc muxing of D inputs.

---
 rtl/shared_reg_arbiter.sv | 140 ++++++++++++++
 tb/tb_shared_reg_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_reg_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : shared_reg_arbiter                                           |
// | Description : Round-robin arbiter and write sequencer for one shared       |
// |               WIDTH-bit register with a programmable post-write guard.     |
// |               Define SHARED_REG_ARB_FIXED_PRI_EN for fixed priority.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module shared_reg_arbiter #(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*WIDTH-1:0]     wdata,
  output logic [N_REQ-1:0]           gnt,
  output logic [WIDTH-1:0]           Q,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   last_id
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [ID_W-1:0]    last_id_q, last_id_d;
  logic [ID_W-1:0]    win_id_q, win_id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               win_found;
  logic [ID_W-1:0]    win_idx;
  logic [ID_W-1:0]    cand;
  logic [WIDTH-1:0]   wdata_arr [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign wdata_arr[gi] = wdata[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Winner search; the loop runs from the lowest-priority candidate up so the
  // last hit (highest priority) is what remains.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
`ifdef SHARED_REG_ARB_FIXED_PRI_EN
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ID_W'(i);
      if (req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
`else
    for (int k = N_REQ; k >= 1; k--) begin
      cand = ID_W'((int'(last_id_q) + k) % N_REQ);
      if (req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = '0;
    q_d       = q_q;
    last_id_d = last_id_q;
    win_id_d  = win_id_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          gnt_d[win_idx] = 1'b1;
          win_id_d       = win_idx;
          state_d        = S_GRANT;
        end
      end
      S_GRANT: begin
        q_d       = wdata_arr[win_id_q];
        last_id_d = win_id_q;
        if (HOLD_CYCLES == 0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
          cnt_d   = CNT_W'(HOLD_CYCLES);
        end
      end
      S_HOLD: begin
        if (cnt_q <= 4'd1) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Reset drops any write in flight: Q clears even mid-GRANT.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      q_q       <= '0;
      last_id_q <= ID_W'(N_REQ - 1);
      win_id_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      q_q       <= q_d;
      last_id_q <= last_id_d;
      win_id_q  <= win_id_d;
      cnt_q     <= cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign Q       = q_q;
  assign busy    = (state_q != S_IDLE);
  assign last_id = last_id_q;

endmodule
`default_nettype wire

// File: tb/tb_shared_reg_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_shared_reg_arbiter                                        |
// | Description : Directed scenarios plus randomized traffic against a         |
// |               cooldown-based reference model of the shared register.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_shared_reg_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int H = 1;

  logic           CLK = 1'b0;
  logic           Reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [W-1:0]   Q;
  logic           busy;
  logic [1:0]     last_id;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a grant opens a window of 1+H edges during which no new
  // grant may happen; the captured data lands one edge after the grant.
  logic [W-1:0] m_q;
  logic [N-1:0] m_gnt;
  int           m_last;
  int           m_cool;
  int           m_pend;
  bit           m_wp;

  shared_reg_arbiter #(.N_REQ(N), .WIDTH(W), .HOLD_CYCLES(H)) dut (
    .CLK    (CLK),
    .Reset  (Reset),
    .req    (req),
    .wdata  (wdata),
    .gnt    (gnt),
    .Q      (Q),
    .busy   (busy),
    .last_id(last_id)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic m_reset();
    m_q    = '0;
    m_gnt  = '0;
    m_last = N - 1;
    m_cool = 0;
    m_pend = 0;
    m_wp   = 1'b0;
  endtask

  function automatic int m_winner(input logic [N-1:0] r);
`ifdef SHARED_REG_ARB_FIXED_PRI_EN
    for (int i = 0; i < N; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (r[(m_last + k) % N]) return (m_last + k) % N;
`endif
    return 0;
  endfunction

  task automatic m_step();
    if (m_wp) begin
      m_q    = wdata[m_pend*W +: W];
      m_last = m_pend;
      m_wp   = 1'b0;
    end
    m_gnt = '0;
    if (m_cool > 0) begin
      m_cool--;
    end else if (req != '0) begin
      m_pend        = m_winner(req);
      m_gnt[m_pend] = 1'b1;
      m_wp          = 1'b1;
      m_cool        = 1 + H;
    end
  endtask

  task automatic do_reset();
    req   = '0;
    wdata = '0;
    @(negedge CLK);
    Reset = 1'b1;
    m_reset();
    @(negedge CLK);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (gnt !== 4'b0000) $display("FAIL rst_gnt: got %b want %b", gnt, 4'b0000); else n_pass++;
    n_checks++; if (Q !== 8'h00) $display("FAIL rst_q: got %h want %h", Q, 8'h00); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want %b", busy, 1'b0); else n_pass++;
    n_checks++; if (last_id !== 2'd3) $display("FAIL rst_last_id: got %0d want %0d", last_id, 3); else n_pass++;
    wdata[1*W +: W] = 8'hA5;
    wdata[0*W +: W] = 8'h77;
    req = 4'b0010;
    tick();
    n_checks++; if (gnt !== 4'b0010) $display("FAIL rst_pre_gnt: got %b want %b", gnt, 4'b0010); else n_pass++;
    #2;
    Reset = 1'b1;
    #1;
    n_checks++; if (gnt !== 4'b0000) $display("FAIL midrst_gnt: got %b want %b", gnt, 4'b0000); else n_pass++;
    n_checks++; if (Q !== 8'h00) $display("FAIL midrst_q: got %h want %h", Q, 8'h00); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want %b", busy, 1'b0); else n_pass++;
    n_checks++; if (last_id !== 2'd3) $display("FAIL midrst_last_id: got %0d want %0d", last_id, 3); else n_pass++;
    req = 4'b0011;
    #1;
    Reset = 1'b0;
    tick();
    n_checks++; if (gnt !== 4'b0001) $display("FAIL postrst_gnt: got %b want %b", gnt, 4'b0001); else n_pass++;
    req = 4'b0010;
    tick();
    n_checks++; if (Q !== 8'h77) $display("FAIL postrst_q: got %h want %h", Q, 8'h77); else n_pass++;
  endtask

  task automatic test_single_write();
    do_reset();
    wdata[2*W +: W] = 8'h3C;
    req = 4'b0100;
    tick();
    n_checks++; if (gnt !== 4'b0100) $display("FAIL sw_gnt: got %b want %b", gnt, 4'b0100); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL sw_busy_grant: got %b want %b", busy, 1'b1); else n_pass++;
    n_checks++; if (Q !== 8'h00) $display("FAIL sw_q_early: got %h want %h", Q, 8'h00); else n_pass++;
    req = 4'b0000;
    tick();
    n_checks++; if (gnt !== 4'b0000) $display("FAIL sw_gnt_drop: got %b want %b", gnt, 4'b0000); else n_pass++;
    n_checks++; if (Q !== 8'h3C) $display("FAIL sw_q: got %h want %h", Q, 8'h3C); else n_pass++;
    n_checks++; if (last_id !== 2'd2) $display("FAIL sw_last_id: got %0d want %0d", last_id, 2); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL sw_busy_hold: got %b want %b", busy, 1'b1); else n_pass++;
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL sw_busy_idle: got %b want %b", busy, 1'b0); else n_pass++;
  endtask

`ifdef SHARED_REG_ARB_FIXED_PRI_EN
  task automatic test_fixed_priority();
    logic [N-1:0] exp_g;
    do_reset();
    wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    req   = 4'b0110;
    for (int t = 0; t < 12; t++) begin
      tick();
      exp_g = (t % 3 == 0) ? 4'b0010 : 4'b0000;
      n_checks++; if (gnt !== exp_g) $display("FAIL fp_gnt t=%0d: got %b want %b", t, gnt, exp_g); else n_pass++;
    end
  endtask
`else
  task automatic test_round_robin();
    logic [N-1:0] exp_g;
    logic [W-1:0] exp_q;
    do_reset();
    wdata = {8'h13, 8'h12, 8'h11, 8'h10};
    req   = 4'b1111;
    for (int t = 0; t < 15; t++) begin
      tick();
      exp_g = (t % 3 == 0) ? N'(1 << ((t / 3) % 4)) : 4'b0000;
      n_checks++; if (gnt !== exp_g) $display("FAIL rr_gnt t=%0d: got %b want %b", t, gnt, exp_g); else n_pass++;
      n_checks++; if ($countones(gnt) > 1) $display("FAIL rr_onehot t=%0d: got %b want at most one bit", t, gnt); else n_pass++;
      if (t % 3 == 1) begin
        exp_q = W'(8'h10 + ((t / 3) % 4));
        n_checks++; if (Q !== exp_q) $display("FAIL rr_q t=%0d: got %h want %h", t, Q, exp_q); else n_pass++;
      end
    end
  endtask
`endif

  task automatic test_wrap();
    do_reset();
    wdata[3*W +: W] = 8'hC3;
    req = 4'b1000;
    tick();
    req = 4'b0000;
    tick();
    tick();
    n_checks++; if (last_id !== 2'd3) $display("FAIL wrap_last_id: got %0d want %0d", last_id, 3); else n_pass++;
    n_checks++; if (Q !== 8'hC3) $display("FAIL wrap_q3: got %h want %h", Q, 8'hC3); else n_pass++;
    wdata[0*W +: W] = 8'h0A;
    req = 4'b1001;
    tick();
    n_checks++; if (gnt !== 4'b0001) $display("FAIL wrap_first: got %b want %b", gnt, 4'b0001); else n_pass++;
    req = 4'b1000;
    tick();
    n_checks++; if (Q !== 8'h0A) $display("FAIL wrap_q0: got %h want %h", Q, 8'h0A); else n_pass++;
    tick();
    n_checks++; if (gnt !== 4'b0000) $display("FAIL wrap_gap: got %b want %b", gnt, 4'b0000); else n_pass++;
    tick();
    n_checks++; if (gnt !== 4'b1000) $display("FAIL wrap_second: got %b want %b", gnt, 4'b1000); else n_pass++;
  endtask

  task automatic test_early_drop();
    do_reset();
    wdata[1*W +: W] = 8'h5A;
    req = 4'b0010;
    tick();
    n_checks++; if (gnt !== 4'b0010) $display("FAIL drop_gnt: got %b want %b", gnt, 4'b0010); else n_pass++;
    req[1] = 1'b0;
    tick();
    n_checks++; if (Q !== 8'h5A) $display("FAIL drop_q: got %h want %h", Q, 8'h5A); else n_pass++;
    n_checks++; if (last_id !== 2'd1) $display("FAIL drop_last_id: got %0d want %0d", last_id, 1); else n_pass++;
    for (int t = 0; t < 6; t++) begin
      tick();
      n_checks++; if (gnt !== 4'b0000) $display("FAIL drop_regrant t=%0d: got %b want %b", t, gnt, 4'b0000); else n_pass++;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge CLK);
      m_step();
      #1;
      n_checks++; if (gnt !== m_gnt) $display("FAIL rnd_gnt c=%0d: got %b want %b", c, gnt, m_gnt); else n_pass++;
      n_checks++; if (Q !== m_q) $display("FAIL rnd_q c=%0d: got %h want %h", c, Q, m_q); else n_pass++;
      n_checks++; if (busy !== (m_cool > 0)) $display("FAIL rnd_busy c=%0d: got %b want %b", c, busy, (m_cool > 0)); else n_pass++;
      n_checks++; if (last_id !== 2'(m_last)) $display("FAIL rnd_last_id c=%0d: got %0d want %0d", c, last_id, m_last); else n_pass++;
      if (c % 500 == 250) begin
        Reset = 1'b1;
        m_reset();
        #1;
        n_checks++; if ({gnt, Q, busy, last_id} !== {4'b0000, 8'h00, 1'b0, 2'd3})
          $display("FAIL rnd_reset c=%0d: got gnt=%b q=%h busy=%b last=%0d want 0000/00/0/3", c, gnt, Q, busy, last_id);
        else n_pass++;
        Reset = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (m_gnt[i]) begin
          if ($urandom_range(3) != 0) req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(2) == 0) begin
          wdata[i*W +: W] = W'($urandom);
          req[i] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    Reset = 1'b1;
    req   = '0;
    wdata = '0;
    m_reset();
    test_reset();
    test_single_write();
`ifdef SHARED_REG_ARB_FIXED_PRI_EN
    test_fixed_priority();
`else
    test_round_robin();
`endif
    test_wrap();
    test_early_drop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
